// File: rtl/mod_n_tick_counter.sv
// Programmable modulo-N tick divider: one-cycle TICK every N enabled clocks,
// a 2N-period WAVE, one-shot mode, immediate LOAD and a wrapping tick count.
module mod_n_tick_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic             MODE,
  input  logic [WIDTH-1:0] N,
  output logic             TICK,
  output logic             WAVE,
  output logic [WIDTH-1:0] COUNT,
  output logic [CNT_W-1:0] TICKS,
  output logic [WIDTH-1:0] ACTIVE_N,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             tick_d, wave_d, busy_d;
  logic [WIDTH-1:0] count_d, active_d;
  logic [CNT_W-1:0] ticks_d;
  logic             terminal;
  logic             n_zero;

  assign n_zero   = (N == '0);
  // ACTIVE_N is never zero while in RUN, so the subtraction cannot underflow there
  assign terminal = (COUNT == ACTIVE_N - WIDTH'(1));

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= IDLE;
      TICK     <= 1'b0;
      WAVE     <= 1'b0;
      COUNT    <= '0;
      TICKS    <= '0;
      ACTIVE_N <= '0;
      BUSY     <= 1'b0;
    end else begin
      state_q  <= state_d;
      TICK     <= tick_d;
      WAVE     <= wave_d;
      COUNT    <= count_d;
      TICKS    <= ticks_d;
      ACTIVE_N <= active_d;
      BUSY     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = 1'b0;
    wave_d   = WAVE;
    count_d  = COUNT;
    ticks_d  = TICKS;
    active_d = ACTIVE_N;

    if (CLR) begin
      state_d  = IDLE;
      wave_d   = 1'b0;
      count_d  = '0;
      ticks_d  = '0;
      active_d = '0;
    end else if (LOAD) begin
      // LOAD outranks a coincident terminal count: the period restarts with no tick
      if (state_q != IDLE || !n_zero) begin
        active_d = N;
        count_d  = '0;
        state_d  = n_zero ? IDLE : RUN;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (EN && !n_zero) begin
            active_d = N;
            count_d  = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (EN) begin
            if (terminal) begin
              count_d  = '0;
              tick_d   = 1'b1;
              wave_d   = ~WAVE;
              ticks_d  = TICKS + CNT_W'(1);
              active_d = N;
              if (n_zero)    state_d = IDLE;
              else if (MODE) state_d = DONE;
            end else begin
              count_d = COUNT + WIDTH'(1);
            end
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

endmodule

// File: doc/mod_n_tick_counter.md
Name: mod_n_tick_counter

Overview:
Parametrised programmable modulo-N divider for timing and event generation. Produces a one-cycle TICK every N enabled clocks and a toggling WAVE, which is a square wave of period 2N. Adds enable, runtime N changes applied glitch-free at the period boundary, an immediate LOAD, a one-shot mode, and a wrapping tick accumulator. It replaces ad-hoc divide-by-N counters wherever a slower strobe or clock-enable is derived from CLK.

Parameters:
WIDTH, 8, width of N, COUNT and ACTIVE_N (max modulus 2^WIDTH-1)
CNT_W, 16, width of the TICKS accumulator

Ports:
CLK  input  1  system clock; all state changes on rising edge
RES  input  1  reset, asynchronous, active-high
EN  input  1  count enable; when 0 all state holds and TICK=0
CLR  input  1  synchronous clear of counter, accumulator, WAVE and FSM
LOAD  input  1  synchronous immediate reload of N, restarting the period
MODE  input  1  0 = periodic, 1 = one-shot
N  input  WIDTH  requested modulus; 0 = stop
TICK  output  1  registered one-cycle strobe at each terminal count
WAVE  output  1  registered, toggles at each terminal count
COUNT  output  WIDTH  current count, 0..ACTIVE_N-1
TICKS  output  CNT_W  number of terminal counts since reset/CLR, wraps modulo 2^CNT_W
ACTIVE_N  output  WIDTH  modulus currently in use (shadow of N)
BUSY  output  1  1 when FSM is in RUN

Behaviour:
- Reset (RES=1, asynchronous, any time): state=IDLE; COUNT=0, TICK=0, WAVE=0, TICKS=0, ACTIVE_N=0, BUSY=0. Release mid-period loses the period; there is no resume.
- Priority per edge: RES > CLR > LOAD > EN counting.
- CLR=1: state=IDLE, COUNT=0, TICKS=0, WAVE=0, TICK=0, ACTIVE_N=0. Applies regardless of EN.
- FSM states: IDLE, RUN, DONE.
- IDLE transitions:
  - EN=1 and N!=0: ACTIVE_N<=N, COUNT<=0, go RUN.
  - EN=1 and N=0: stay IDLE.
  - EN=0: hold.
- RUN, EN=1, no LOAD, non-terminal (COUNT != ACTIVE_N-1): COUNT<=COUNT+1, TICK<=0.
- RUN, EN=1, terminal (COUNT == ACTIVE_N-1):
  - COUNT<=0, TICK<=1, WAVE<=~WAVE, TICKS<=TICKS+1 (wraps).
  - ACTIVE_N<=N, so a new N takes effect only at the period boundary.
  - N=0 at terminal: go IDLE, ACTIVE_N<=0.
  - MODE=1: go DONE instead of continuing.
- RUN, EN=0: COUNT, WAVE, TICKS, ACTIVE_N hold; TICK=0; the period stretches.
- LOAD=1 in RUN or DONE, any EN:
  - ACTIVE_N<=N, COUNT<=0, TICK<=0; WAVE and TICKS unchanged; go RUN.
  - N=0: go IDLE instead.
  - LOAD coincident with terminal: LOAD wins, no tick and no TICKS increment.
- LOAD in IDLE: same as the IDLE entry rule, but does not require EN.
- DONE: COUNT=0, TICK=0, all other outputs hold. Leaves only via CLR (to IDLE), LOAD (to RUN/IDLE) or RES. Changing MODE while in DONE has no effect.
- Latency: the edge entering RUN leaves COUNT=0. With EN held high, TICK is high in the cycle after the ACTIVE_N-th subsequent edge, then every ACTIVE_N cycles.
- N=1: terminal every enabled cycle, TICK stays high continuously and WAVE toggles every cycle (period 2).
- N = 2^WIDTH-1: COUNT reaches 2^WIDTH-2 and never wraps through all-ones.
- Changing N mid-period has no effect until the terminal count or LOAD.
- BUSY = (state==RUN). All outputs are registered; there is no combinational input-to-output path.

Test Plan:
1. RES pulse, then EN=1, N=4, MODE=0 for 20 cycles -> RUN entry, TICK high exactly every 4th cycle, WAVE period 8, TICKS counts 1,2,3,4; COUNT sequence 0,1,2,3,0.
2. N=4 running; change N to 2 at COUNT=1 -> current period still completes at COUNT=3; after that TICKs every 2 cycles and ACTIVE_N reads 2 after the boundary.
3. N=3, MODE=1 -> exactly one TICK, TICKS=1, FSM reaches DONE with BUSY=0 and no further ticks for 10 cycles; LOAD with N=5 -> RUN, next TICK 5 cycles later.
4. N=5; LOAD asserted on the terminal cycle -> no TICK, TICKS unchanged, COUNT=0; EN=0 for 3 cycles mid-period -> COUNT frozen, tick delayed by exactly 3 cycles.
5. N=1 -> TICK constantly 1, WAVE toggles each cycle; CNT_W=4 after 16 ticks -> TICKS wraps to 0; N=0 at a terminal -> IDLE, ACTIVE_N=0, TICK stays 0.
6. RES asserted asynchronously between edges mid-count -> all outputs 0 immediately; CLR while COUNT=2, TICKS=7 -> next edge all cleared and IDLE.
